// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - eight-digit multiplexed seven-segment scan driver
//
// Purpose:
//   Scans a 32-bit display word onto eight shared seven-segment digits. Each
//   nibble is shown as one hex digit, one digit at a time, in rotation. The
//   word is copied into a shadow register once per frame, so a CPU write that
//   lands mid-frame never shows part old value and part new value.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (2 or more)
//   LZ_BLANK  1 blanks leading zero digits (digit 0 always shown)
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset
//   cs      display enable, 0 blanks the outputs (scan keeps running)
//   i_data  display word, digit k shows i_data[4k+3:4k]
//   o_seg   segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   o_sel   digit select, one-hot active-low, registered

module seg_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [31:0] i_data,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel
);

    localparam int            CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    dig;
    logic [31:0]   shadow;
    logic          dead;

    logic          tick;
    logic          wrap;
    logic [4:0]    nib_base;
    logic [3:0]    nib;
    logic [31:0]   upper;
    logic          lz;

    assign tick     = (cnt == CNT_LAST);
    assign wrap     = tick && (dig == 3'd7);
    assign nib_base = {dig, 2'b00};
    assign nib      = shadow[nib_base +: 4];

    // Nibbles dig..7 of the shadow word; all zero means this digit is a
    // leading zero. Digit 0 is exempt so a zero word still shows "0".
    assign upper = shadow >> nib_base;
    assign lz    = LZ_BLANK && (dig != 3'd0) && (upper == 32'd0);

    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            dig    <= 3'd0;
            shadow <= 32'd0;
            dead   <= 1'b1;
            o_sel  <= 8'hFF;
            o_seg  <= 8'hFF;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                dig <= dig + 3'd1;
            end
            // Snapshot only at the frame boundary so a frame is never torn.
            if (wrap && cs) begin
                shadow <= i_data;
            end
            // One blank cycle at the start of every slot lets the previous
            // digit's driver turn off before the next one turns on.
            dead <= tick;
            if (!cs || dead) begin
                o_sel <= 8'hFF;
                o_seg <= 8'hFF;
            end else begin
                o_sel <= ~(8'd1 << dig);
                o_seg <= lz ? 8'hFF : hex7(nib);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver

module tb_seg_scan_driver;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [31:0] d0, d1, d2;
    logic [7:0]  sel0, seg0, sel1, seg1, sel2, seg2;

    int checks;
    int errors;
    int cyc;

    seg_scan_driver #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) u0 (
        .clk(clk), .reset(reset), .cs(cs), .i_data(d0), .o_seg(seg0), .o_sel(sel0)
    );
    seg_scan_driver #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) u1 (
        .clk(clk), .reset(reset), .cs(cs), .i_data(d1), .o_seg(seg1), .o_sel(sel1)
    );
    seg_scan_driver #(.SCAN_DIV(2), .LZ_BLANK(1'b0)) u2 (
        .clk(clk), .reset(reset), .cs(cs), .i_data(d2), .o_seg(seg2), .o_sel(sel2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after rising edge number n since reset release.
    task automatic adv(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        cs = 1'b1;
        d0 = 32'h1234ABCD;
        d2 = 32'h1234ABCD;
        do_reset();
        adv(1);
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL reset_first_blank got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        adv(2);
        checks++; if ({sel0, seg0} !== 16'hFEC0) begin errors++; $display("FAIL reset_first_digit got %h exp %h", {sel0, seg0}, 16'hFEC0); end
        adv(5);
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL reset_slot1_blank got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        adv(6);
        checks++; if ({sel0, seg0} !== 16'hFDC0) begin errors++; $display("FAIL reset_slot1_zero got %h exp %h", {sel0, seg0}, 16'hFDC0); end
    endtask

    task automatic test_full_decode();
        cs = 1'b1;
        d0 = 32'h1234ABCD;
        do_reset();
        adv(33);
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL decode_wrap_blank got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        adv(34);
        checks++; if ({sel0, seg0} !== 16'hFEA1) begin errors++; $display("FAIL decode_dig0 got %h exp %h", {sel0, seg0}, 16'hFEA1); end
        adv(36);
        checks++; if ({sel0, seg0} !== 16'hFEA1) begin errors++; $display("FAIL decode_dig0_last got %h exp %h", {sel0, seg0}, 16'hFEA1); end
        adv(37);
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL decode_dig1_blank got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        adv(38);
        checks++; if ({sel0, seg0} !== 16'hFDC6) begin errors++; $display("FAIL decode_dig1 got %h exp %h", {sel0, seg0}, 16'hFDC6); end
        adv(50);
        checks++; if ({sel0, seg0} !== 16'hEF99) begin errors++; $display("FAIL decode_dig4 got %h exp %h", {sel0, seg0}, 16'hEF99); end
        adv(53);
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL decode_dig5_blank got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        adv(62);
        checks++; if ({sel0, seg0} !== 16'h7FF9) begin errors++; $display("FAIL decode_dig7 got %h exp %h", {sel0, seg0}, 16'h7FF9); end
        adv(64);
        checks++; if ({sel0, seg0} !== 16'h7FF9) begin errors++; $display("FAIL decode_dig7_last got %h exp %h", {sel0, seg0}, 16'h7FF9); end
    endtask

    // Continues from test_full_decode: second frame, digit 5 on display.
    task automatic test_reset_mid_frame();
        adv(86);
        checks++; if ({sel0, seg0} !== 16'hDFB0) begin errors++; $display("FAIL midreset_before got %h exp %h", {sel0, seg0}, 16'hDFB0); end
        reset = 1'b1;
        #2;
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL midreset_async u0 got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        checks++; if ({sel2, seg2} !== 16'hFFFF) begin errors++; $display("FAIL midreset_async u2 got %h exp %h", {sel2, seg2}, 16'hFFFF); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        adv(1);
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL midreset_c1 got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        adv(2);
        checks++; if ({sel0, seg0} !== 16'hFEC0) begin errors++; $display("FAIL midreset_c2 got %h exp %h", {sel0, seg0}, 16'hFEC0); end
        adv(6);
        checks++; if ({sel0, seg0} !== 16'hFDC0) begin errors++; $display("FAIL midreset_c6 got %h exp %h", {sel0, seg0}, 16'hFDC0); end
    endtask

    task automatic test_tear_free();
        cs = 1'b1;
        d0 = 32'h1234ABCD;
        do_reset();
        adv(44);
        d0 = 32'hFFFFFFFF;
        adv(54);
        checks++; if ({sel0, seg0} !== 16'hDFB0) begin errors++; $display("FAIL tear_dig5_old got %h exp %h", {sel0, seg0}, 16'hDFB0); end
        adv(64);
        checks++; if ({sel0, seg0} !== 16'h7FF9) begin errors++; $display("FAIL tear_dig7_old got %h exp %h", {sel0, seg0}, 16'h7FF9); end
        adv(65);
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL tear_blank got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        adv(66);
        checks++; if ({sel0, seg0} !== 16'hFE8E) begin errors++; $display("FAIL tear_dig0_new got %h exp %h", {sel0, seg0}, 16'hFE8E); end
        adv(78);
        checks++; if ({sel0, seg0} !== 16'hF78E) begin errors++; $display("FAIL tear_dig3_new got %h exp %h", {sel0, seg0}, 16'hF78E); end
    endtask

    task automatic test_chip_select();
        cs = 1'b1;
        d0 = 32'h1234ABCD;
        do_reset();
        adv(34);
        checks++; if ({sel0, seg0} !== 16'hFEA1) begin errors++; $display("FAIL cs_initial got %h exp %h", {sel0, seg0}, 16'hFEA1); end
        adv(40);
        d0 = 32'hFFFFFFFF;
        adv(50);
        checks++; if ({sel0, seg0} !== 16'hEF99) begin errors++; $display("FAIL cs_before_drop got %h exp %h", {sel0, seg0}, 16'hEF99); end
        cs = 1'b0;
        adv(51);
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL cs_low_next got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        adv(60);
        checks++; if ({sel0, seg0} !== 16'hFFFF) begin errors++; $display("FAIL cs_low_hold got %h exp %h", {sel0, seg0}, 16'hFFFF); end
        adv(70);
        cs = 1'b1;
        adv(71);
        checks++; if ({sel0, seg0} !== 16'hFDC6) begin errors++; $display("FAIL cs_resume_old got %h exp %h", {sel0, seg0}, 16'hFDC6); end
        adv(98);
        checks++; if ({sel0, seg0} !== 16'hFE8E) begin errors++; $display("FAIL cs_next_load got %h exp %h", {sel0, seg0}, 16'hFE8E); end
    endtask

    task automatic test_lz_blank();
        cs = 1'b1;
        d0 = 32'h00000050;
        d1 = 32'h00000050;
        do_reset();
        adv(6);
        checks++; if ({sel1, seg1} !== 16'hFDFF) begin errors++; $display("FAIL lz_prewrap u1 got %h exp %h", {sel1, seg1}, 16'hFDFF); end
        checks++; if ({sel0, seg0} !== 16'hFDC0) begin errors++; $display("FAIL lz_prewrap u0 got %h exp %h", {sel0, seg0}, 16'hFDC0); end
        adv(34);
        checks++; if ({sel1, seg1} !== 16'hFEC0) begin errors++; $display("FAIL lz_dig0 got %h exp %h", {sel1, seg1}, 16'hFEC0); end
        adv(38);
        checks++; if ({sel1, seg1} !== 16'hFD92) begin errors++; $display("FAIL lz_dig1 got %h exp %h", {sel1, seg1}, 16'hFD92); end
        adv(42);
        checks++; if ({sel1, seg1} !== 16'hFBFF) begin errors++; $display("FAIL lz_dig2 got %h exp %h", {sel1, seg1}, 16'hFBFF); end
        checks++; if ({sel0, seg0} !== 16'hFBC0) begin errors++; $display("FAIL lz_off_dig2 got %h exp %h", {sel0, seg0}, 16'hFBC0); end
        adv(62);
        checks++; if ({sel1, seg1} !== 16'h7FFF) begin errors++; $display("FAIL lz_dig7 got %h exp %h", {sel1, seg1}, 16'h7FFF); end

        d1 = 32'h00000000;
        do_reset();
        adv(34);
        checks++; if ({sel1, seg1} !== 16'hFEC0) begin errors++; $display("FAIL lz_zero_dig0 got %h exp %h", {sel1, seg1}, 16'hFEC0); end
        adv(38);
        checks++; if ({sel1, seg1} !== 16'hFDFF) begin errors++; $display("FAIL lz_zero_dig1 got %h exp %h", {sel1, seg1}, 16'hFDFF); end

        d1 = 32'h00000105;
        do_reset();
        adv(38);
        checks++; if ({sel1, seg1} !== 16'hFDC0) begin errors++; $display("FAIL lz_inner_zero got %h exp %h", {sel1, seg1}, 16'hFDC0); end
        adv(42);
        checks++; if ({sel1, seg1} !== 16'hFBF9) begin errors++; $display("FAIL lz_dig2_one got %h exp %h", {sel1, seg1}, 16'hFBF9); end
        adv(46);
        checks++; if ({sel1, seg1} !== 16'hF7FF) begin errors++; $display("FAIL lz_dig3_blank got %h exp %h", {sel1, seg1}, 16'hF7FF); end
    endtask

    task automatic test_min_div();
        cs = 1'b1;
        d2 = 32'h1234ABCD;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            adv(n);
            if (n % 2 == 1) begin
                checks++; if ({sel2, seg2} !== 16'hFFFF) begin errors++; $display("FAIL mindiv_blank c%0d got %h exp %h", n, {sel2, seg2}, 16'hFFFF); end
            end else begin
                checks++; if ($countones(~sel2) != 1) begin errors++; $display("FAIL mindiv_onehot c%0d got %h exp one low bit", n, sel2); end
            end
            if (n == 2) begin
                checks++; if ({sel2, seg2} !== 16'hFEC0) begin errors++; $display("FAIL mindiv_c2 got %h exp %h", {sel2, seg2}, 16'hFEC0); end
            end
            if (n == 16) begin
                checks++; if ({sel2, seg2} !== 16'h7FC0) begin errors++; $display("FAIL mindiv_c16 got %h exp %h", {sel2, seg2}, 16'h7FC0); end
            end
            if (n == 18) begin
                checks++; if ({sel2, seg2} !== 16'hFEA1) begin errors++; $display("FAIL mindiv_c18 got %h exp %h", {sel2, seg2}, 16'hFEA1); end
            end
            if (n == 32) begin
                checks++; if ({sel2, seg2} !== 16'h7FF9) begin errors++; $display("FAIL mindiv_c32 got %h exp %h", {sel2, seg2}, 16'h7FF9); end
            end
            if (n == 34) begin
                checks++; if ({sel2, seg2} !== 16'hFEA1) begin errors++; $display("FAIL mindiv_c34 got %h exp %h", {sel2, seg2}, 16'hFEA1); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        cs     = 1'b0;
        d0     = 32'd0;
        d1     = 32'd0;
        d2     = 32'd0;
        test_reset();
        test_full_decode();
        test_reset_mid_frame();
        test_tear_free();
        test_chip_select();
        test_lz_blank();
        test_min_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed eight-digit seven-segment scan driver. It consumes the 32-bit display word latched by the memory-mapped display register and drives the board's shared segment and digit-select lines. Each nibble is rendered as one hex digit, refreshed in rotation. The word is snapshotted once per frame so that mid-frame CPU writes never tear the display.

## Interface
Parameters:
- SCAN_DIV, 100000 — clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range is 2 or more.
- LZ_BLANK, 0 — 1 enables leading-zero blanking.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  display enable; 0 blanks all outputs.
- i_data  input  32  display word; digit k shows i_data[4k+3:4k].
- o_seg  output  8  segment pattern {dp,g,f,e,d,c,b,a}, active-low, registered.
- o_sel  output  8  digit select, one-hot active-low (bit k low selects digit k), registered.

## Operation
- Prescaler `cnt`: counts 0..SCAN_DIV-1 and wraps. `tick` = (cnt == SCAN_DIV-1).
- Digit index `dig` (3 bits): increments on each tick and wraps 7→0.
- Shadow register `shadow` (32 bits): loads i_data on the edge where dig wraps 7→0, but only if cs=1 on that edge. Otherwise it holds its value.
- Dead flag: set on every tick edge and cleared on the next edge. It marks the first cycle of each slot, which is used for anti-ghosting.
- Output registers load each edge from the pre-edge values of dig, shadow, cs and dead:
  - If cs=0 or dead=1: o_sel=8'hFF and o_seg=8'hFF.
  - Otherwise: o_sel = ~(1<<dig), and o_seg = hex(shadow[4*dig+3:4*dig]).
- Hex decode table (active-low, dp=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Leading-zero blanking (LZ_BLANK=1): for dig≠0, if shadow nibbles dig..7 are all zero, then o_seg=8'hFF. o_sel still selects the digit. Digit 0 is never blanked.
- cs does not stop the counters. The scan continues, so re-enabling cs resumes in phase.
- Reset (asynchronous, any time, including mid-frame) sets:
  - cnt=0, dig=0, shadow=0, dead=1
  - o_sel=8'hFF, o_seg=8'hFF
- The display shows 0 until the first 7→0 wrap with cs=1. This first wrap occurs 8·SCAN_DIV cycles after reset release.

## Timing
- Slot length is SCAN_DIV cycles; frame length is 8·SCAN_DIV cycles.
- Outputs lag internal state by exactly one clock.
- Per slot, the first output cycle is blank. The remaining SCAN_DIV-1 cycles drive the digit.
- A change on i_data becomes visible at the first slot after the next cs=1 wrap. The maximum latency is 8·SCAN_DIV+1 cycles.
- A cs falling edge blanks the outputs on the next edge (1 cycle). A cs rising edge shows the current shadow on the next edge, unless that cycle is a dead cycle.
- cs toggling on the wrap edge follows the rule for that edge: shadow loads only if cs=1 sampled at the wrap edge.
- Exactly one o_sel bit is low at any time, or none. Two or more bits low simultaneously is illegal.

## Test plan
1. **Reset mid-frame** (SCAN_DIV=4): assert reset during dig=5 → o_sel=FF and o_seg=FF asynchronously. After release, cnt=0 and dig=0, and the first non-blank output is o_sel=FE, o_seg=C0 at cycle 2.
2. **Full decode** (SCAN_DIV=4, cs=1, i_data=32'h1234ABCD): after the first wrap, the slots show:
   - dig0: o_sel=FE, o_seg=A1
   - dig1: FD/C6
   - dig4: EF/99
   - dig7: 7F/F9
   - Each slot is 1 blank cycle followed by 3 driven cycles.
3. **Tear-free update**: change i_data to 32'hFFFFFFFF mid-frame → the remaining digits of the current frame still show the old value. All digits show 8E from the next frame.
4. **Chip select** (cs=0 for 20 cycles): o_sel=FF and o_seg=FF from the next edge. The counters keep advancing. With cs=0 at a wrap, shadow retains its old value. Raising cs resumes in the correct slot.
5. **Leading-zero blanking** (LZ_BLANK=1, i_data=32'h00000050): dig0 shows C0, dig1 shows 92, and dig2..7 show o_seg=FF with o_sel still cycling. For i_data=0, only dig0 shows C0.
6. **Minimum divider** (SCAN_DIV=2): alternating blank and driven cycles. The frame is 16 cycles, and o_sel is never multi-hot.
